obi_demux_1_to_n: RTL and testbench
===================================

// Module: obi_demux_1_to_n
// PURPOSE
//  - Parametrised OBI demux: one OBI master to N_PORTS OBI slaves, each mapped to an inclusive address window.
//  - Supports pipelined transactions: up to MAX_OUTSTANDING accepted, unanswered transactions.
//  - Keeps responses in order by stalling the grant when the target port changes while responses are pending.
//  - Every accepted transaction, read or write, receives exactly one rvalid.
//  - Sits between a core/DMA master and the crossbar slave side; successor of the fixed 1-to-2 demux.
// PARAMETERS
//  N_PORTS          2                       number of slave ports, 1..16
//  PORT_BASE_ADDRS  {32'h80000000,32'h00001000}  packed N_PORTS*32; port k base = [k*32+:32]
//  PORT_END_ADDRS   {32'h8000FFFF,32'h00001FFF}  packed N_PORTS*32; port k end, inclusive
//  MAX_OUTSTANDING  4                       max accepted-but-unanswered transactions, >=1
//  ERR_RDATA        32'hDEADBEEF            rdata returned for unmapped accesses
// PORTS
//  clk_i            in   1          clock, all state on rising edge
//  rst_i            in   1          synchronous, active-high reset
//  ctrl_req_i       in   1          master request
//  ctrl_gnt_o       out  1          grant to master
//  ctrl_addr_i      in   32         address
//  ctrl_we_i        in   1          write enable
//  ctrl_be_i        in   4          byte enables
//  ctrl_wdata_i     in   32         write data
//  ctrl_rvalid_o    out  1          response valid
//  ctrl_rdata_o     out  32         response data
//  port_req_o       out  N_PORTS    per-port request, one-hot or zero
//  port_gnt_i       in   N_PORTS    per-port grant
//  port_addr_o      out  32         broadcast of ctrl_addr_i
//  port_we_o        out  1          broadcast of ctrl_we_i
//  port_be_o        out  4          broadcast of ctrl_be_i
//  port_wdata_o     out  32         broadcast of ctrl_wdata_i
//  port_rvalid_i    in   N_PORTS    per-port response valid
//  port_rdata_i     in   N_PORTS*32 per-port rdata, port k at [k*32+:32]
//  bad_state_o      out  1          protocol/mapping error flag, combinational
// BEHAVIOUR
//  - Decode: addr_sel = lowest k with base_k<=addr<=end_k; no hit -> ERR target (index N_PORTS).
//  - State: cnt (0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1)), resp_sel (0..N_PORTS).
//  - Reset, same cycle: cnt=0, resp_sel=0, err_pend=0.
//  - Outputs while rst_i is high: port_req_o=0, ctrl_gnt_o=0, ctrl_rvalid_o=0, ctrl_rdata_o=0.
//  - Reset mid-operation drops all pending responses; late slave rvalids are ignored.
//  - stall = (cnt==MAX_OUTSTANDING) | (cnt!=0 & addr_sel!=resp_sel).
//  - port_req_o[k] = ctrl_req_i & !stall & addr_sel==k.
//  - ctrl_gnt_o = !stall & (addr_sel<N_PORTS ? port_gnt_i[addr_sel] : ERR grant, see CONFIGURATION).
//  - Accept = ctrl_req_i & ctrl_gnt_o; on accept, resp_sel <= addr_sel.
//  - Response, port target: ctrl_rvalid_o = (cnt!=0) & port_rvalid_i[resp_sel]; rdata is muxed from resp_sel.
//  - With no response pending, ctrl_rvalid_o=0 and ctrl_rdata_o=0.
//  - Response, ERR target: rvalid is registered (err_pend), exactly 1 cycle after accept, with ERR_RDATA.
//  - cnt: +1 on accept, -1 on ctrl_rvalid_o; both in the same cycle -> unchanged.
//  - Zero-latency slave responses are allowed: rvalid may come the cycle after gnt, back-to-back every cycle.
//  - Throughput: a stream to one port sustains 1 txn/cycle.
//  - A port switch costs a drain to cnt==0; accept on the new port is allowed in the same cycle cnt reaches 0 is not possible (cnt is registered).
//  - bad_state_o = (any port_rvalid_i[k] with cnt==0 or k!=resp_sel) | (ctrl_req_i & addr_sel==N_PORTS).
//  - Stray rvalids are never forwarded to the master.
// CONFIGURATION
//  - OBI_DEMUX_ERR_RESP_EN defined: unmapped requests are granted when not stalled and answered via the ERR path above.
//  - OBI_DEMUX_ERR_RESP_EN undefined: unmapped requests are never granted (ctrl_gnt_o=0) and no port_req_o is raised.
//    In this case the master hangs and bad_state_o stays high while ctrl_req_i is held.
// TESTING
//  1. Reset held 2 cycles with ctrl_req_i=1 -> gnt=0, port_req_o=0, rvalid=0, rdata=0; release -> req routes.
//  2. Four back-to-back reads to 0x1000..0x100C, port0 gnt=1, rvalid the next cycle each -> 4 gnts in 4 cycles.
//     rdata returned in order; cnt peaks at 1.
//  3. Port0 gnt=1 but rvalid withheld, 5 reads -> 4 accepted, 5th stalls (gnt=0) until first rvalid.
//     Fifth is accepted the cycle after that rvalid.
//  4. Read 0x1000 (port0, pending), then write 0x80000000 -> port_req_o[1]=0, gnt=0 until port0 rvalid.
//     Next cycle port1 is requested; the write also gets one rvalid.
//  5. ERR_RESP_EN on, read 0x40000000 -> gnt same cycle, rvalid next cycle, rdata=32'hDEADBEEF, bad_state_o=1 while req.
//     ERR_RESP_EN off -> gnt stays 0.
//  6. port_rvalid_i[1]=1 with cnt==0 -> ctrl_rvalid_o=0, bad_state_o=1; cnt stays 0.

Source files
------------

// File: rtl/obi_demux_1_to_n.sv
// obi_demux_1_to_n: in-order pipelined OBI demux routing one master onto N_PORTS address-windowed slaves
// Define OBI_DEMUX_ERR_RESP_EN to grant and answer unmapped accesses with ERR_RDATA.
module obi_demux_1_to_n #(
  parameter int                    N_PORTS         = 2,
  parameter logic [N_PORTS*32-1:0] PORT_BASE_ADDRS = {32'h80000000, 32'h00001000},
  parameter logic [N_PORTS*32-1:0] PORT_END_ADDRS  = {32'h8000FFFF, 32'h00001FFF},
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [31:0]           ERR_RDATA       = 32'hDEADBEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ctrl_req_i,
  output logic                    ctrl_gnt_o,
  input  logic [31:0]             ctrl_addr_i,
  input  logic                    ctrl_we_i,
  input  logic [3:0]              ctrl_be_i,
  input  logic [31:0]             ctrl_wdata_i,
  output logic                    ctrl_rvalid_o,
  output logic [31:0]             ctrl_rdata_o,
  output logic [N_PORTS-1:0]      port_req_o,
  input  logic [N_PORTS-1:0]      port_gnt_i,
  output logic [31:0]             port_addr_o,
  output logic                    port_we_o,
  output logic [3:0]              port_be_o,
  output logic [31:0]             port_wdata_o,
  input  logic [N_PORTS-1:0]      port_rvalid_i,
  input  logic [N_PORTS*32-1:0]   port_rdata_i,
  output logic                    bad_state_o
);
  localparam int SW = $clog2(N_PORTS + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW-1:0] ERR_SEL = SW'(N_PORTS);
`ifdef OBI_DEMUX_ERR_RESP_EN
  localparam logic ERR_GNT = 1'b1;
`else
  localparam logic ERR_GNT = 1'b0;
`endif
  logic [SW-1:0]      addr_sel, resp_sel;
  logic [CW-1:0]      cnt;
  logic               err_pend, pend, stall, sel_gnt, resp_hit, accept;
  logic [N_PORTS-1:0] resp_oh;
  logic [31:0]        resp_rdata;
  assign port_addr_o  = ctrl_addr_i;
  assign port_we_o    = ctrl_we_i;
  assign port_be_o    = ctrl_be_i;
  assign port_wdata_o = ctrl_wdata_i;
  // Descending scan so the lowest matching window wins on overlap
  always_comb begin
    addr_sel = ERR_SEL;
    for (int k = N_PORTS - 1; k >= 0; k--)
      if (ctrl_addr_i >= PORT_BASE_ADDRS[k*32+:32] && ctrl_addr_i <= PORT_END_ADDRS[k*32+:32])
        addr_sel = SW'(k);
  end
  always_comb begin
    sel_gnt    = ERR_GNT;
    resp_oh    = '0;
    resp_rdata = ERR_RDATA;
    resp_hit   = err_pend;
    for (int k = 0; k < N_PORTS; k++) begin
      if (addr_sel == SW'(k)) sel_gnt = port_gnt_i[k];
      if (resp_sel == SW'(k)) begin
        resp_oh[k] = 1'b1;
        resp_rdata = port_rdata_i[k*32+:32];
        resp_hit   = port_rvalid_i[k];
      end
    end
  end
  assign pend          = cnt != '0;
  assign stall         = (cnt == CW'(MAX_OUTSTANDING)) | (pend & (addr_sel != resp_sel));
  assign ctrl_gnt_o    = !rst_i & !stall & sel_gnt;
  assign accept        = ctrl_req_i & ctrl_gnt_o;
  assign ctrl_rvalid_o = !rst_i & pend & resp_hit;
  assign ctrl_rdata_o  = (!rst_i & pend) ? resp_rdata : '0;
  assign bad_state_o   = |(port_rvalid_i & ~(resp_oh & {N_PORTS{pend}})) | (ctrl_req_i & (addr_sel == ERR_SEL));
  always_comb begin
    port_req_o = '0;
    for (int k = 0; k < N_PORTS; k++)
      port_req_o[k] = !rst_i & ctrl_req_i & !stall & (addr_sel == SW'(k));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      resp_sel <= '0;
      err_pend <= 1'b0;
    end else begin
      if (accept) resp_sel <= addr_sel;
      err_pend <= accept & (addr_sel == ERR_SEL);
      cnt      <= cnt + CW'(accept) - CW'(ctrl_rvalid_o);
    end
  end
endmodule

// File: tb/tb_obi_demux_1_to_n.sv
// tb_obi_demux_1_to_n: directed tests of routing, pipelining, ordering stalls, error path and stray rvalids
module tb_obi_demux_1_to_n;
  logic        clk = 0, rst = 1;
  logic        req = 0, gnt, we = 0, rvalid, bad;
  logic [31:0] addr = 0, wdata = 0, rdata, p_addr, p_wdata;
  logic [3:0]  be = 4'hF, p_be;
  logic        p_we;
  logic [1:0]  p_req, p_gnt = 0, p_rvalid = 0;
  logic [31:0] rd0 = 0, rd1 = 0;
  int          pass = 0, total = 0;

  obi_demux_1_to_n dut (
    .clk_i(clk), .rst_i(rst), .ctrl_req_i(req), .ctrl_gnt_o(gnt), .ctrl_addr_i(addr),
    .ctrl_we_i(we), .ctrl_be_i(be), .ctrl_wdata_i(wdata), .ctrl_rvalid_o(rvalid),
    .ctrl_rdata_o(rdata), .port_req_o(p_req), .port_gnt_i(p_gnt), .port_addr_o(p_addr),
    .port_we_o(p_we), .port_be_o(p_be), .port_wdata_o(p_wdata), .port_rvalid_i(p_rvalid),
    .port_rdata_i({rd1, rd0}), .bad_state_o(bad)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req = 1; addr = 32'h1000; p_gnt = 2'b11; p_rvalid = 2'b11; rd0 = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      if ({gnt, p_req, rvalid, rdata} !== 36'h0) $display("FAIL reset_outputs gnt=%b req=%b rvalid=%b rdata=%h exp all zero", gnt, p_req, rvalid, rdata); else pass++; total++;
    end
    rst = 0; p_rvalid = 0;
    #1;
    if (p_req !== 2'b01) $display("FAIL reset_release_req got=%b exp=01", p_req); else pass++; total++;
    if (gnt !== 1'b1) $display("FAIL reset_release_gnt got=%b exp=1", gnt); else pass++; total++;
    if (rvalid !== 1'b0) $display("FAIL reset_release_rvalid got=%b exp=0", rvalid); else pass++; total++;
    req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    p_gnt = 2'b01; we = 0;
    for (int i = 0; i < 5; i++) begin
      req = (i < 4); addr = 32'h1000 + 32'(i * 4);
      p_rvalid = {1'b0, i > 0}; rd0 = 32'hA0000000 + 32'(i - 1);
      #1;
      if (i < 4 && gnt !== 1'b1) $display("FAIL b2b_gnt%0d got=%b exp=1", i, gnt); else if (i < 4) pass++;
      if (i < 4) total++;
      if (i > 0) begin
        if ({rvalid, rdata} !== {1'b1, 32'hA0000000 + 32'(i - 1)}) $display("FAIL b2b_resp%0d rvalid=%b rdata=%h exp=1/%h", i, rvalid, rdata, 32'hA0000000 + 32'(i - 1)); else pass++; total++;
      end
      tick();
    end
    p_rvalid = 0; req = 0;
    #1;
    if (rvalid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", rvalid); else pass++; total++;
  endtask

  task automatic test_max_outstanding();
    p_gnt = 2'b01; p_rvalid = 0; req = 1; addr = 32'h1004;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (gnt !== 1'b1) $display("FAIL maxo_gnt%0d got=%b exp=1", i, gnt); else pass++; total++;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      if ({gnt, p_req} !== 3'b000) $display("FAIL maxo_stall%0d gnt=%b req=%b exp=0/00", i, gnt, p_req); else pass++; total++;
      tick();
    end
    p_rvalid = 2'b01; rd0 = 32'hC0FFEE00;
    #1;
    if ({rvalid, gnt} !== 2'b10) $display("FAIL maxo_first_resp rvalid=%b gnt=%b exp=1/0", rvalid, gnt); else pass++; total++;
    tick();
    p_rvalid = 0;
    #1;
    if (gnt !== 1'b1) $display("FAIL maxo_fifth_gnt got=%b exp=1", gnt); else pass++; total++;
    tick();
    req = 0; p_rvalid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rvalid !== 1'b1) $display("FAIL maxo_drain%0d got=%b exp=1", i, rvalid); else pass++; total++;
      tick();
    end
    p_rvalid = 0;
    #1;
    if (bad !== 1'b0) $display("FAIL maxo_clean got=%b exp=0", bad); else pass++; total++;
  endtask

  task automatic test_port_switch();
    p_gnt = 2'b11; req = 1; we = 0; addr = 32'h1000;
    #1;
    if ({p_req, gnt} !== 3'b011) $display("FAIL sw_first req=%b gnt=%b exp=01/1", p_req, gnt); else pass++; total++;
    tick();
    addr = 32'h80000000; we = 1; wdata = 32'h12345678; be = 4'h3;
    #1;
    if ({p_req, gnt} !== 3'b000) $display("FAIL sw_stall req=%b gnt=%b exp=00/0", p_req, gnt); else pass++; total++;
    if ({p_we, p_be, p_addr, p_wdata} !== {1'b1, 4'h3, 32'h80000000, 32'h12345678}) $display("FAIL sw_broadcast we=%b be=%h addr=%h wdata=%h", p_we, p_be, p_addr, p_wdata); else pass++; total++;
    tick();
    p_rvalid = 2'b01; rd0 = 32'h0BADF00D;
    #1;
    if ({rvalid, rdata, gnt, p_req} !== {1'b1, 32'h0BADF00D, 1'b0, 2'b00}) $display("FAIL sw_resp0 rvalid=%b rdata=%h gnt=%b req=%b exp=1/0badf00d/0/00", rvalid, rdata, gnt, p_req); else pass++; total++;
    tick();
    p_rvalid = 0;
    #1;
    if ({p_req, gnt} !== 3'b101) $display("FAIL sw_second req=%b gnt=%b exp=10/1", p_req, gnt); else pass++; total++;
    tick();
    req = 0; we = 0; be = 4'hF; p_rvalid = 2'b10; rd1 = 32'h55AA55AA;
    #1;
    if ({rvalid, rdata, bad} !== {1'b1, 32'h55AA55AA, 1'b0}) $display("FAIL sw_resp1 rvalid=%b rdata=%h bad=%b exp=1/55aa55aa/0", rvalid, rdata, bad); else pass++; total++;
    tick();
    p_rvalid = 0;
  endtask

  task automatic test_err();
    p_gnt = 2'b11; req = 1; addr = 32'h40000000;
    #1;
`ifdef OBI_DEMUX_ERR_RESP_EN
    if ({gnt, p_req, bad} !== 4'b1001) $display("FAIL err_gnt gnt=%b req=%b bad=%b exp=1/00/1", gnt, p_req, bad); else pass++; total++;
    tick();
    req = 0;
    #1;
    if ({rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL err_resp rvalid=%b rdata=%h exp=1/deadbeef", rvalid, rdata); else pass++; total++;
    tick();
    #1;
    if (rvalid !== 1'b0) $display("FAIL err_single got=%b exp=0", rvalid); else pass++; total++;
`else
    if ({gnt, p_req, bad} !== 4'b0001) $display("FAIL err_nogrant gnt=%b req=%b bad=%b exp=0/00/1", gnt, p_req, bad); else pass++; total++;
    tick();
    #1;
    if ({gnt, rvalid, bad} !== 3'b001) $display("FAIL err_hang gnt=%b rvalid=%b bad=%b exp=0/0/1", gnt, rvalid, bad); else pass++; total++;
    req = 0;
    #1;
    if (bad !== 1'b0) $display("FAIL err_release got=%b exp=0", bad); else pass++; total++;
`endif
  endtask

  task automatic test_stray();
    req = 0; p_rvalid = 2'b10; rd1 = 32'hFFFF0000;
    #1;
    if ({rvalid, bad, rdata} !== {1'b0, 1'b1, 32'h0}) $display("FAIL stray rvalid=%b bad=%b rdata=%h exp=0/1/0", rvalid, bad, rdata); else pass++; total++;
    tick();
    p_rvalid = 2'b01;
    #1;
    if ({rvalid, bad} !== 2'b01) $display("FAIL stray_cnt0 rvalid=%b bad=%b exp=0/1", rvalid, bad); else pass++; total++;
    tick();
    p_rvalid = 0;
    #1;
    if (bad !== 1'b0) $display("FAIL stray_clear got=%b exp=0", bad); else pass++; total++;
  endtask

  task automatic test_reset_mid();
    p_gnt = 2'b01; req = 1; addr = 32'h1000;
    tick();
    req = 0; rst = 1;
    tick();
    rst = 0; p_rvalid = 2'b01; rd0 = 32'h77777777;
    #1;
    if ({rvalid, bad} !== 2'b01) $display("FAIL reset_mid_drop rvalid=%b bad=%b exp=0/1", rvalid, bad); else pass++; total++;
    tick();
    p_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_max_outstanding();
    test_port_switch();
    test_err();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
